// File: rtl/baud_tick_ctrl_if.sv
// Divisor configuration handshake between the register block
// and the baud tick scheduler.
interface baud_tick_ctrl_if #(
  parameter int DIV_W = 16
);
  logic [DIV_W-1:0] CFG_DIV;
  logic             CFG_VALID;
  logic             CFG_READY;
  logic             CFG_ERR;

  modport master (
    output CFG_DIV,
    output CFG_VALID,
    input  CFG_READY,
    input  CFG_ERR
  );

  modport slave (
    input  CFG_DIV,
    input  CFG_VALID,
    output CFG_READY,
    output CFG_ERR
  );
endinterface

// File: rtl/baud_tick_ctrl.sv
// Programmable oversample/mid-bit/bit clock-enable scheduler
// with bit-boundary divisor switching and RX re-phasing.
module baud_tick_ctrl #(
  parameter int DIV_W   = 16,
  parameter int OVS     = 16,
  parameter int DIV_RST = 54
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  baud_tick_ctrl_if.slave       cfg,
  input  logic                  RX_ALIGN,
  output logic [DIV_W-1:0]      CUR_DIV,
  output logic                  OVS_CE,
  output logic                  MID_CE,
  output logic                  BAUD_CE
);

  localparam int PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             ovs_q, ovs_d;
  logic             mid_q, mid_d;
  logic             baud_q, baud_d;
  logic             err_q, err_d;

  logic cfg_ready;
  logic xfer;
  logic take;
  logic tick;
  logic last;

  assign cfg_ready = (state_q != PEND);
  assign xfer      = cfg.CFG_VALID & cfg_ready;
  assign take      = xfer & (cfg.CFG_DIV != '0);
  assign tick      = (cnt_q == cur_div_q - DIV_W'(1));
  assign last      = (phase_q == PH_LAST);

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    ovs_d     = 1'b0;
    mid_d     = 1'b0;
    baud_d    = 1'b0;
    err_d     = xfer & (cfg.CFG_DIV == '0);

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = '0;
        if (take) cur_div_d = cfg.CFG_DIV;
        if (EN)   state_d   = RUN;
      end
      RUN, PEND: begin
        if (!EN) begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = '0;
          if (state_q == PEND) cur_div_d = pend_q;
          if (take)            cur_div_d = cfg.CFG_DIV;
        end else begin
          if (RX_ALIGN) begin
            cnt_d   = '0;
            phase_d = '0;
          end else if (tick) begin
            cnt_d   = '0;
            ovs_d   = 1'b1;
            mid_d   = (phase_q == PH_MID);
            baud_d  = last;
            phase_d = last ? '0 : phase_q + PH_W'(1);
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // Pending divisor lands on realign or on the bit tick
          if (state_q == PEND && (RX_ALIGN || (tick && last))) begin
            cur_div_d = pend_q;
            state_d   = RUN;
          end
          if (take) begin
            pend_d  = cfg.CFG_DIV;
            state_d = PEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cur_div_q <= DIV_W'(DIV_RST);
      pend_q    <= '0;
      cnt_q     <= '0;
      phase_q   <= '0;
      ovs_q     <= 1'b0;
      mid_q     <= 1'b0;
      baud_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      ovs_q     <= ovs_d;
      mid_q     <= mid_d;
      baud_q    <= baud_d;
      err_q     <= err_d;
    end
  end

  assign cfg.CFG_READY = cfg_ready;
  assign cfg.CFG_ERR   = err_q;
  assign CUR_DIV       = cur_div_q;
  assign OVS_CE        = ovs_q;
  assign MID_CE        = mid_q;
  assign BAUD_CE       = baud_q;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// Directed bench for baud_tick_ctrl with OVS=4, DIV_RST=3.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_baud_tick_ctrl;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             rx_align = 1'b0;
  logic [DIV_W-1:0] cur_div;
  logic             ovs_ce, mid_ce, baud_ce;

  int checks = 0;
  int errors = 0;

  baud_tick_ctrl_if #(.DIV_W(DIV_W)) cfg ();

  baud_tick_ctrl #(
    .DIV_W  (DIV_W),
    .OVS    (4),
    .DIV_RST(3)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .cfg     (cfg.slave),
    .RX_ALIGN(rx_align),
    .CUR_DIV (cur_div),
    .OVS_CE  (ovs_ce),
    .MID_CE  (mid_ce),
    .BAUD_CE (baud_ce)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    rx_align = 1'b0;
    cfg.CFG_VALID = 1'b0;
    cfg.CFG_DIV = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(int div);
    cfg.CFG_DIV = DIV_W'(div);
    cfg.CFG_VALID = 1'b1;
    step();
    cfg.CFG_VALID = 1'b0;
  endtask

  // Steps until OVS_CE, checks gap and the tick flags
  task automatic wait_tick(string tag, int gap_e,
                           int mid_e, int baud_e);
    int   gap;
    logic stray;
    gap = -1;
    stray = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (ovs_ce) begin
        gap = i;
        break;
      end
      if (mid_ce | baud_ce) stray = 1'b1;
    end
    chk({tag, ".gap"}, gap, gap_e);
    chk({tag, ".mid"}, int'(mid_ce), mid_e);
    chk({tag, ".baud"}, int'(baud_ce), baud_e);
    chk({tag, ".stray"}, int'(stray), 0);
  endtask

  initial begin
    cfg.CFG_DIV = '0;
    cfg.CFG_VALID = 1'b0;

    // 1: reset state and default rate
    do_reset();
    chk("rst.ovs", int'(ovs_ce), 0);
    chk("rst.mid", int'(mid_ce), 0);
    chk("rst.baud", int'(baud_ce), 0);
    chk("rst.err", int'(cfg.CFG_ERR), 0);
    chk("rst.rdy", int'(cfg.CFG_READY), 1);
    chk("rst.div", int'(cur_div), 3);
    en = 1'b1;
    wait_tick("t1.k1", 4, 0, 0);
    wait_tick("t1.k2", 3, 1, 0);
    wait_tick("t1.k3", 3, 0, 0);
    wait_tick("t1.k4", 3, 0, 1);
    wait_tick("t1.k5", 3, 0, 0);
    wait_tick("t1.k6", 3, 1, 0);
    wait_tick("t1.k7", 3, 0, 0);
    wait_tick("t1.k8", 3, 0, 1);

    // 2: divisor load in IDLE
    do_reset();
    chk("t2.rdy", int'(cfg.CFG_READY), 1);
    send(5);
    chk("t2.div", int'(cur_div), 5);
    en = 1'b1;
    wait_tick("t2.k1", 6, 0, 0);
    wait_tick("t2.k2", 5, 1, 0);

    // 3: divisor change mid-bit waits for BAUD_CE
    do_reset();
    en = 1'b1;
    wait_tick("t3.k1", 4, 0, 0);
    chk("t3.rdy0", int'(cfg.CFG_READY), 1);
    send(2);
    chk("t3.pend", int'(cfg.CFG_READY), 0);
    wait_tick("t3.k2", 2, 1, 0);
    wait_tick("t3.k3", 3, 0, 0);
    chk("t3.olddiv", int'(cur_div), 3);
    chk("t3.rdy1", int'(cfg.CFG_READY), 0);
    wait_tick("t3.k4", 3, 0, 1);
    chk("t3.newdiv", int'(cur_div), 2);
    chk("t3.rdy2", int'(cfg.CFG_READY), 1);
    wait_tick("t3.k5", 2, 0, 0);
    wait_tick("t3.k6", 2, 1, 0);

    // 4: RX_ALIGN one cycle before a tick
    do_reset();
    en = 1'b1;
    wait_tick("t4.k1", 4, 0, 0);
    step();
    step();
    rx_align = 1'b1;
    step();
    rx_align = 1'b0;
    chk("t4.sup", int'(ovs_ce), 0);
    wait_tick("t4.a1", 3, 0, 0);
    wait_tick("t4.a2", 3, 1, 0);
    wait_tick("t4.a3", 3, 0, 0);
    wait_tick("t4.a4", 3, 0, 1);

    // 5: zero divisor is rejected
    send(0);
    chk("t5.err", int'(cfg.CFG_ERR), 1);
    chk("t5.div", int'(cur_div), 3);
    chk("t5.rdy", int'(cfg.CFG_READY), 1);
    step();
    chk("t5.err0", int'(cfg.CFG_ERR), 0);
    wait_tick("t5.k1", 1, 0, 0);
    wait_tick("t5.k2", 3, 1, 0);

    // 6a: reset while pending discards the new divisor
    do_reset();
    en = 1'b1;
    wait_tick("t6.k1", 4, 0, 0);
    send(7);
    chk("t6.pend", int'(cfg.CFG_READY), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.ovs", int'(ovs_ce), 0);
    chk("t6.mid", int'(mid_ce), 0);
    chk("t6.baud", int'(baud_ce), 0);
    chk("t6.div", int'(cur_div), 3);
    chk("t6.rdy", int'(cfg.CFG_READY), 1);

    // 6b: EN=0 while pending applies the new divisor
    do_reset();
    en = 1'b1;
    wait_tick("t6b.k1", 4, 0, 0);
    send(6);
    chk("t6b.pend", int'(cfg.CFG_READY), 0);
    en = 1'b0;
    step();
    chk("t6b.div", int'(cur_div), 6);
    chk("t6b.rdy", int'(cfg.CFG_READY), 1);
    chk("t6b.ovs", int'(ovs_ce), 0);
    step();
    chk("t6b.idle", int'(ovs_ce), 0);

    // divisor of 1 ticks every cycle
    do_reset();
    send(1);
    chk("d1.div", int'(cur_div), 1);
    en = 1'b1;
    wait_tick("d1.k1", 2, 0, 0);
    wait_tick("d1.k2", 1, 1, 0);
    wait_tick("d1.k3", 1, 0, 0);
    wait_tick("d1.k4", 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
